// File: rtl/sseg_mux.sv
// sseg_mux: time-multiplexed DIGITS-position 7-segment driver with per-slot blanking and frame-latched shadow image.
// Define SSEG_MUX_LZ_SUPPRESS_EN to blank leading-zero glyphs (digit 0 always shown).
module sseg_mux #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 1000,
    parameter int BLANK   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [7:0]            segments,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frame_start
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
    localparam state_t SLOT_START = BLANK > 0 ? S_BLANK : S_SHOW;

    state_t              r_state, w_state;
    logic [CW-1:0]       r_cnt, w_cnt;
    logic [IW-1:0]       r_idx, w_idx;
    logic [4*DIGITS-1:0] r_val, w_val;
    logic [DIGITS-1:0]   r_dp, w_dp, r_den, w_den, r_an, w_an;
    logic [7:0]          r_seg, w_seg;
    logic                r_fs, w_cap, w_lit, w_lz;
    logic [3:0]          w_nib;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_cap   = 1'b0;
        if (!en) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_idx   = '0;
        end else if (r_state == S_IDLE) begin
            w_state = SLOT_START;
            w_cnt   = '0;
            w_idx   = '0;
            w_cap   = 1'b1;
        end else if (r_cnt == CW'(CLK_DIV - 1)) begin
            w_state = SLOT_START;
            w_cnt   = '0;
            w_idx   = r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1;
            w_cap   = r_idx == IW'(DIGITS - 1);
        end else begin
            w_cnt   = r_cnt + 1'b1;
            w_state = (r_state == S_BLANK && r_cnt == CW'(BLANK - 1)) ? S_SHOW : r_state;
        end
    end

    // Outputs are derived from the next-state image so they register on the same edge as the state.
    always_comb begin
        w_val = w_cap ? value : r_val;
        w_dp  = w_cap ? dp : r_dp;
        w_den = w_cap ? digit_en : r_den;
        w_nib = w_val[4*w_idx +: 4];
        w_lit = w_state == S_SHOW && w_den[w_idx];
`ifdef SSEG_MUX_LZ_SUPPRESS_EN
        w_lz  = w_idx != '0 && (w_val >> (4*w_idx)) == '0;
`else
        w_lz  = 1'b0;
`endif
        w_seg = w_lit ? {w_dp[w_idx], w_lz ? 7'h00 : glyph(w_nib)} : 8'h00;
        w_an  = w_lit ? DIGITS'(1) << w_idx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_val   <= '0;
            r_dp    <= '0;
            r_den   <= '0;
            r_seg   <= '0;
            r_an    <= '0;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_val   <= w_val;
            r_dp    <= w_dp;
            r_den   <= w_den;
            r_seg   <= w_seg;
            r_an    <= w_an;
            r_fs    <= w_cap;
        end
    end

    assign segments    = r_seg;
    assign anodes      = r_an;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_sseg_mux.sv
// tb_sseg_mux: scoreboard bench for sseg_mux with DIGITS=4, CLK_DIV=4, BLANK=1.
module tb_sseg_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  digit_en = '0;
    logic [7:0]  segments;
    logic [3:0]  anodes;
    logic        frame_start;
    int          checks = 0;
    int          errors = 0;
    logic [12:0] sb[$];
    logic [12:0] exp_v;
    logic [6:0]  glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sseg_mux #(.DIGITS(4), .CLK_DIV(4), .BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .digit_en(digit_en),
        .segments(segments), .anodes(anodes), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Expected {frame_start, anodes, segments} for each of the 16 cycles of one frame.
    function automatic void push_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] de);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                logic       lit, lz;
                logic [3:0] an;
                logic [7:0] seg;
                logic [15:0] up;
                lit = c > 0 && de[s];
                up  = v >> (4*s);
`ifdef SSEG_MUX_LZ_SUPPRESS_EN
                lz  = s > 0 && up == 16'h0;
`else
                lz  = 1'b0;
`endif
                an  = lit ? 4'(1 << s) : 4'h0;
                seg = lit ? {d[s], lz ? 7'h00 : glyph_tbl[up[3:0]]} : 8'h00;
                sb.push_back({s == 0 && c == 0, an, seg});
            end
        end
    endfunction

    task automatic start(input logic [15:0] v, input logic [3:0] d, input logic [3:0] de);
        en = 1'b0;
        @(posedge clk); #1;
        value = v;
        dp = d;
        digit_en = de;
        en = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({frame_start, anodes, segments} !== 13'h0) begin
            errors++;
            $display("FAIL reset_init: fs/an/seg got %b/%b/%h expected 0/0000/00", frame_start, anodes, segments);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({frame_start, anodes, segments} !== 13'h0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: fs/an/seg got %b/%b/%h expected 0/0000/00", i, frame_start, anodes, segments);
            end
        end
        start(16'h12AF, 4'b0100, 4'hF);
        push_frame(16'h12AF, 4'b0100, 4'hF);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({frame_start, anodes, segments} !== exp_v) begin
                errors++;
                $display("FAIL reset_prescan[%0d]: got %b/%b/%h expected %b/%b/%h", i, frame_start, anodes, segments, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
        sb.delete();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({frame_start, anodes, segments} !== 13'h0) begin
            errors++;
            $display("FAIL reset_async: fs/an/seg got %b/%b/%h expected 0/0000/00", frame_start, anodes, segments);
        end
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({frame_start, anodes, segments} !== 13'h0) begin
                errors++;
                $display("FAIL reset_release[%0d]: fs/an/seg got %b/%b/%h expected 0/0000/00", i, frame_start, anodes, segments);
            end
        end
    endtask

    task automatic test_scan_order();
        start(16'h12AF, 4'b0100, 4'hF);
        push_frame(16'h12AF, 4'b0100, 4'hF);
        push_frame(16'h12AF, 4'b0100, 4'hF);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({frame_start, anodes, segments} !== exp_v) begin
                errors++;
                $display("FAIL scan[%0d]: got %b/%b/%h expected %b/%b/%h", i, frame_start, anodes, segments, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
    endtask

    task automatic test_tearing();
        start(16'h12AF, 4'b0100, 4'hF);
        push_frame(16'h12AF, 4'b0100, 4'hF);
        push_frame(16'h0000, 4'b0100, 4'hF);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({frame_start, anodes, segments} !== exp_v) begin
                errors++;
                $display("FAIL tearing[%0d]: got %b/%b/%h expected %b/%b/%h", i, frame_start, anodes, segments, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
            if (i == 5) value = 16'h0000;
        end
    endtask

    task automatic test_enable_drop();
        start(16'h12AF, 4'b0100, 4'hF);
        push_frame(16'h12AF, 4'b0100, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({frame_start, anodes, segments} !== exp_v) begin
                errors++;
                $display("FAIL drop_pre[%0d]: got %b/%b/%h expected %b/%b/%h", i, frame_start, anodes, segments, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
        sb.delete();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({frame_start, anodes, segments} !== 13'h0) begin
                errors++;
                $display("FAIL drop_dark[%0d]: fs/an/seg got %b/%b/%h expected 0/0000/00", i, frame_start, anodes, segments);
            end
        end
        push_frame(16'h12AF, 4'b0100, 4'hF);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({frame_start, anodes, segments} !== exp_v) begin
                errors++;
                $display("FAIL drop_restart[%0d]: got %b/%b/%h expected %b/%b/%h", i, frame_start, anodes, segments, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
        sb.delete();
    endtask

    task automatic test_digit_en();
        start(16'h12AF, 4'b1111, 4'b1010);
        push_frame(16'h12AF, 4'b1111, 4'b1010);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({frame_start, anodes, segments} !== exp_v) begin
                errors++;
                $display("FAIL digit_en[%0d]: got %b/%b/%h expected %b/%b/%h", i, frame_start, anodes, segments, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
    endtask

    task automatic test_leading_zero();
        start(16'h0005, 4'b0000, 4'hF);
        push_frame(16'h0005, 4'b0000, 4'hF);
        push_frame(16'h0000, 4'b0000, 4'hF);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({frame_start, anodes, segments} !== exp_v) begin
                errors++;
                $display("FAIL lz[%0d]: got %b/%b/%h expected %b/%b/%h", i, frame_start, anodes, segments, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
            if (i == 0) value = 16'h0000;
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tearing();
        test_enable_drop();
        test_digit_en();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sseg_mux.md
# sseg_mux

Time-multiplexed multi-digit 7-segment display driver. It scans `DIGITS` common-anode/cathode positions, one at a time, using the same hex glyph set as the single-digit decoder. Each digit slot starts with an anti-ghosting blank interval. A complete display image is latched at frame boundaries, so a frame never mixes old and new values. The block sits between register-mapped display data and the board's shared segment bus plus per-digit select lines.

## Interface
Parameters:
- `DIGITS`, 4, number of digit positions; legal range 1..16.
- `CLK_DIV`, 1000, clock cycles per digit slot; must be ≥2.
- `BLANK`, 2, cycles at the start of each slot with all outputs dark; must be < `CLK_DIV`; 0 disables blanking.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: scan enable; when low, the display is dark.
- `value` in 4*DIGITS: hex nibbles; digit i is `value[4i+3:4i]`; digit 0 is least significant.
- `dp` in DIGITS: decimal point for each digit.
- `digit_en` in DIGITS: per-digit enable; a 0 keeps that slot dark.
- `segments` out 8: bit0=a … bit6=g, bit7=dp; active-high.
- `anodes` out DIGITS: one-hot digit select, active-high; all-zero means dark.
- `frame_start` out 1: one-cycle pulse when the shadow image is captured.

## Operation
- State machine states: IDLE, BLANK, SHOW.
- Registers:
  - slot counter `cnt` counts 0..CLK_DIV-1.
  - digit index `idx` counts 0..DIGITS-1.
  - shadow copies of `value`, `dp` and `digit_en`.
- Moore outputs, registered. They update on the same edge as the state.
- IDLE:
  - Outputs are 0; `cnt` and `idx` are held at 0.
  - When `en`=1, go to BLANK on the next edge (or to SHOW if `BLANK`=0). On that edge: `idx`=0, `cnt`=0, shadow is captured, `frame_start`=1.
- `cnt` increments every cycle while enabled.
- BLANK → SHOW when `cnt`==BLANK-1.
- At `cnt`==CLK_DIV-1:
  - `cnt`←0 and the state goes to BLANK (or SHOW if `BLANK`=0).
  - `idx`←idx+1, wrapping from DIGITS-1 to 0.
  - On the wrap to 0: capture the shadow and pulse `frame_start`.
- BLANK: `anodes`=0 and `segments`=0.
- SHOW, with `digit_en`[idx] set in the shadow:
  - `anodes`=1<<idx.
  - `segments`[6:0] = glyph of the shadow nibble.
  - `segments`[7] = shadow `dp`[idx].
- SHOW, with `digit_en`[idx] clear: `anodes`=0 and `segments`=0 for the whole slot.
- Glyphs (hex, {g..a}): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- `en` falling in any state:
  - Go to IDLE on the next edge, with all outputs 0 and `cnt`/`idx` cleared.
  - Re-enabling restarts at digit 0 with a fresh capture.
- `DIGITS`=1: `idx` stays 0, and the capture and `frame_start` occur every slot.

## Timing
- Reset: state IDLE; `cnt`, `idx` and shadow = 0; `segments`=0, `anodes`=0, `frame_start`=0.
- Latency:
  - `en` rise to `frame_start` = 1 cycle.
  - First lit digit follows `BLANK` cycles later.
- Each slot is `BLANK` dark cycles followed by CLK_DIV-BLANK lit cycles.
- Frame period = DIGITS*CLK_DIV cycles. `frame_start` is periodic at this interval while `en`=1.
- Input changes are invisible until the next `frame_start` edge. A change sampled on the capture edge itself is taken.
- Never more than one `anodes` bit is high.

## Configuration
- `SSEG_MUX_LZ_SUPPRESS_EN` defined: leading-zero suppression.
  - Evaluated on the shadow image.
  - Digits above the highest nonzero nibble have `segments`[6:0]=0.
  - Digit 0 is never suppressed.
  - The `dp` bit and the anode still follow `dp`/`digit_en`.
- Undefined: every enabled digit shows its glyph, including zeros.

## Test plan
All scenarios use `DIGITS`=4, `CLK_DIV`=4, `BLANK`=1.
- Reset: assert `rst_n`=0 mid-scan → `segments`=0, `anodes`=0 and `frame_start`=0 immediately, without waiting for a clock edge. After release, the block stays in IDLE while `en`=0.
- Scan order: `value`=16'h12AF, `dp`=4'b0100, `digit_en`=4'hF, then raise `en` → `frame_start` pulses one cycle later, then repeats every 16 cycles. Each slot has 1 dark cycle, then 3 cycles lit:
  - anodes 0001 / segments 71
  - 0010 / 77
  - 0100 / DB
  - 1000 / 06
- Tearing: change `value` to 16'h0000 during slot 1 → slots 2 and 3 still show 5B|80 and 06. After the next `frame_start`, every digit shows 3F.
- Enable drop: drop `en` during slot 2 SHOW → all outputs are 0 on the next edge. On re-raise, `frame_start` pulses and digit 0 is lit after 1 blank cycle.
- Digit enable: `digit_en`=4'b1010 → slots 0 and 2 have `anodes`=0 and `segments`=0 for all 4 cycles; slots 1 and 3 are normal.
- Leading-zero suppression: with `SSEG_MUX_LZ_SUPPRESS_EN`, `value`=16'h0005 → digits 3..1 show `segments`=00 and digit 0 shows 6D. With `value`=0, digit 0 shows 3F. Without the macro, digits 3..1 show 3F.
